// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with a per-register pending-write
// scoreboard for RAW hazard detection. Register 0 reads zero, ignores writes
// and is never pending.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data (and clear busy) on the read ports.
module reg_file_mp #(
   parameter int XLEN    = 32,
   parameter int NUM_REG = 8,
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 2,
   parameter int AW      = $clog2(NUM_REG)
) (
   input  logic                     clk_i,
   input  logic                     arst_ni,
   input  logic [NUM_WR-1:0]        wr_en_i,
   input  logic [NUM_WR*AW-1:0]     wr_addr_i,
   input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
   input  logic [NUM_RD*AW-1:0]     rd_addr_i,
   output logic [NUM_RD*XLEN-1:0]   rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     issue_en_i,
   input  logic [AW-1:0]            issue_addr_i,
   output logic                     any_pending_o
);

   logic [XLEN-1:0]    regs_q [NUM_REG];
   logic [XLEN-1:0]    regs_d [NUM_REG];
   logic [NUM_REG-1:0] pend_q;
   logic [NUM_REG-1:0] pend_d;

   // Next state: ports applied in ascending order so the highest index wins
   // an address conflict; issue is applied last so it beats a writeback.
   always_comb begin : write_next
      regs_d = regs_q;
      pend_d = pend_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
            regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
            pend_d[wr_addr_i[w*AW +: AW]] = 1'b0;
         end
      end
      if (issue_en_i && (issue_addr_i != '0)) begin
         pend_d[issue_addr_i] = 1'b1;
      end
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   // Register storage and pending bits, cleared asynchronously.
   always_ff @(posedge clk_i or negedge arst_ni) begin : state_ff
      if (!arst_ni) begin
         for (int r = 0; r < NUM_REG; r++) begin
            regs_q[r] <= '0;
         end
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   // Combinational read ports; outputs are forced quiet while in reset.
   always_comb begin : read_ports
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
         rd_busy_o[p]              = pend_q[rd_addr_i[p*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (rd_addr_i[p*AW +: AW] != '0) &&
                (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
               rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
               rd_busy_o[p]              = 1'b0;
            end
         end
`endif
      end
      if (!arst_ni) begin
         rd_data_o = '0;
         rd_busy_o = '0;
      end
   end

   // Summary of registered pending state only, never bypassed.
   assign any_pending_o = |pend_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed scenarios plus randomized traffic for reg_file_mp,
// checked against an array-based reference model of the register file.
module tb_reg_file_mp;

  localparam int XLEN    = 32;
  localparam int NUM_REG = 8;
  localparam int NUM_RD  = 2;
  localparam int NUM_WR  = 2;
  localparam int AW      = $clog2(NUM_REG);

  logic                   clk_i = 1'b0;
  logic                   arst_ni;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   issue_en;
  logic [AW-1:0]          issue_addr;
  logic                   any_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] mdl_reg  [NUM_REG];
  bit              mdl_pend [NUM_REG];
  logic [XLEN-1:0] exp_q [$];

  reg_file_mp #(.XLEN(XLEN), .NUM_REG(NUM_REG), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .any_pending_o(any_pending)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic set_wr(input int w, input bit en, input int a, input logic [XLEN-1:0] d);
    logic [AW-1:0] aa;
    aa = a[AW-1:0];
    wr_en[w] = en;
    wr_addr[w*AW +: AW] = aa;
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    logic [AW-1:0] aa;
    aa = a[AW-1:0];
    rd_addr[p*AW +: AW] = aa;
  endtask

  // ---------------- reference model ----------------
  function automatic int wr_a(input int w);
    return int'(wr_addr[w*AW +: AW]);
  endfunction

  // Architectural update of one clock edge, register by register.
  task automatic model_step();
    for (int r = 1; r < NUM_REG; r++) begin
      int winner;
      winner = -1;
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_a(w) == r) winner = w;
      if (winner >= 0) mdl_reg[r] = wr_data[winner*XLEN +: XLEN];
      if (issue_en && int'(issue_addr) == r) mdl_pend[r] = 1'b1;
      else if (winner >= 0) mdl_pend[r] = 1'b0;
    end
  endtask

  function automatic logic [XLEN-1:0] m_rd_data(input int p);
    int a;
    a = int'(rd_addr[p*AW +: AW]);
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    for (int w = NUM_WR-1; w >= 0; w--)
      if (wr_en[w] && wr_a(w) == a) return wr_data[w*XLEN +: XLEN];
`endif
    return mdl_reg[a];
  endfunction

  function automatic bit m_rd_busy(input int p);
    int a;
    a = int'(rd_addr[p*AW +: AW]);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_a(w) == a) return 1'b0;
`endif
    return mdl_pend[a];
  endfunction

  function automatic bit m_any();
    bit any;
    any = 1'b0;
    for (int r = 0; r < NUM_REG; r++) any |= mdl_pend[r];
    return any;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_ni = 1'b0;
    for (int r = 0; r < NUM_REG; r++) begin mdl_reg[r] = '0; mdl_pend[r] = 1'b0; end
    wr_en = '1; wr_data = '1;
    set_wr(0, 1, 3, 32'hFFFF_FFFF);
    set_wr(1, 1, 5, 32'hFFFF_FFFF);
    set_rd(0, 3); set_rd(1, 5);
    issue_en = 1'b1; issue_addr = 3'd3;
    repeat (3) @(posedge clk_i);
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      n_checks++;
      if (rd_data[p*XLEN +: XLEN] !== '0) begin
        n_fail++; $display("FAIL reset_rd_data p%0d got=%h exp=0", p, rd_data[p*XLEN +: XLEN]);
      end
      n_checks++;
      if (rd_busy[p] !== 1'b0) begin
        n_fail++; $display("FAIL reset_rd_busy p%0d got=%b exp=0", p, rd_busy[p]);
      end
    end
    n_checks++;
    if (any_pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_any_pending got=%b exp=0", any_pending);
    end
    idle();
    #2 arst_ni = 1'b1;
    @(negedge clk_i);
    for (int r = 0; r < NUM_REG; r++) begin
      set_rd(r % NUM_RD, r);
      #1;
      n_checks++;
      if (rd_data[(r % NUM_RD)*XLEN +: XLEN] !== '0) begin
        n_fail++; $display("FAIL post_reset_read r%0d got=%h exp=0", r, rd_data[(r % NUM_RD)*XLEN +: XLEN]);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    idle();
    set_wr(0, 1, 3, 32'hA5A5_0001);
    set_wr(1, 1, 5, 32'h0000_1234);
    tick(); idle();
    set_rd(0, 3); set_rd(1, 5); #1;
    n_checks++;
    if (rd_data[0 +: XLEN] !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL basic_r3 got=%h exp=a5a50001", rd_data[0 +: XLEN]);
    end
    n_checks++;
    if (rd_data[XLEN +: XLEN] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL basic_r5 got=%h exp=00001234", rd_data[XLEN +: XLEN]);
    end
    set_wr(0, 1, 0, 32'hDEAD_BEEF);
    tick(); idle();
    set_rd(0, 0); #1;
    n_checks++;
    if (rd_data[0 +: XLEN] !== '0) begin
      n_fail++; $display("FAIL basic_r0 got=%h exp=0", rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_conflict();
    idle();
    set_wr(0, 1, 2, 32'h1111);
    set_wr(1, 1, 2, 32'h2222);
    tick(); idle();
    set_rd(1, 2); #1;
    n_checks++;
    if (rd_data[XLEN +: XLEN] !== 32'h2222) begin
      n_fail++; $display("FAIL conflict_high_wins got=%h exp=00002222", rd_data[XLEN +: XLEN]);
    end
    set_wr(0, 1, 2, 32'h1111);
    tick(); idle(); #1;
    n_checks++;
    if (rd_data[XLEN +: XLEN] !== 32'h1111) begin
      n_fail++; $display("FAIL conflict_port0_alone got=%h exp=00001111", rd_data[XLEN +: XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(0, 4);
    issue_en = 1'b1; issue_addr = 3'd4;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_same_cycle_issue got=%b exp=0", rd_busy[0]);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL sb_busy_set got=%b exp=1", rd_busy[0]);
    end
    n_checks++;
    if (any_pending !== 1'b1) begin
      n_fail++; $display("FAIL sb_any_set got=%b exp=1", any_pending);
    end
    set_wr(1, 1, 4, 32'h77);
    tick(); idle(); #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_busy_clear got=%b exp=0", rd_busy[0]);
    end
    n_checks++;
    if (any_pending !== 1'b0) begin
      n_fail++; $display("FAIL sb_any_clear got=%b exp=0", any_pending);
    end
    n_checks++;
    if (rd_data[0 +: XLEN] !== 32'h77) begin
      n_fail++; $display("FAIL sb_data got=%h exp=00000077", rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_collision();
    idle();
    issue_en = 1'b1; issue_addr = 3'd6;
    tick();
    set_wr(0, 1, 6, 32'h99);
    tick(); idle();
    set_rd(1, 6); #1;
    n_checks++;
    if (rd_data[XLEN +: XLEN] !== 32'h99) begin
      n_fail++; $display("FAIL coll_data got=%h exp=00000099", rd_data[XLEN +: XLEN]);
    end
    n_checks++;
    if (rd_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL coll_busy got=%b exp=1", rd_busy[1]);
    end
    n_checks++;
    if (any_pending !== 1'b1) begin
      n_fail++; $display("FAIL coll_any got=%b exp=1", any_pending);
    end
    set_wr(0, 1, 6, 32'h99);
    tick(); idle();
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] old_v;
    idle();
    set_wr(0, 1, 7, 32'h0000_0BAD);
    issue_en = 1'b1; issue_addr = 3'd7;
    tick(); idle();
    old_v = 32'h0000_0BAD;
    set_rd(0, 7);
    set_wr(1, 1, 7, 32'h0000_DEAD);
    #1;
`ifdef REG_FILE_BYPASS_EN
    n_checks++;
    if (rd_data[0 +: XLEN] !== 32'h0000_DEAD) begin
      n_fail++; $display("FAIL bypass_data got=%h exp=0000dead", rd_data[0 +: XLEN]);
    end
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_busy got=%b exp=0", rd_busy[0]);
    end
`else
    n_checks++;
    if (rd_data[0 +: XLEN] !== old_v) begin
      n_fail++; $display("FAIL nobypass_data got=%h exp=%h", rd_data[0 +: XLEN], old_v);
    end
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL nobypass_busy got=%b exp=1", rd_busy[0]);
    end
`endif
    n_checks++;
    if (any_pending !== 1'b1) begin
      n_fail++; $display("FAIL bypass_any_unbypassed got=%b exp=1", any_pending);
    end
    tick(); idle(); #1;
    n_checks++;
    if (rd_data[0 +: XLEN] !== 32'h0000_DEAD || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_next_cycle got=%h/%b exp=0000dead/0", rd_data[0 +: XLEN], rd_busy[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int w = 0; w < NUM_WR; w++)
        set_wr(w, ($urandom_range(0, 2) != 0), $urandom_range(0, NUM_REG-1), $urandom);
      issue_en = ($urandom_range(0, 2) == 0);
      issue_addr = AW'($urandom_range(0, NUM_REG-1));
      for (int p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(0, NUM_REG-1));
      #1;
      for (int p = 0; p < NUM_RD; p++) exp_q.push_back(m_rd_data(p));
      for (int p = 0; p < NUM_RD; p++) begin
        logic [XLEN-1:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (rd_data[p*XLEN +: XLEN] !== e) begin
          n_fail++; $display("FAIL rand_data c%0d p%0d got=%h exp=%h", c, p, rd_data[p*XLEN +: XLEN], e);
        end
        n_checks++;
        if (rd_busy[p] !== m_rd_busy(p)) begin
          n_fail++; $display("FAIL rand_busy c%0d p%0d got=%b exp=%b", c, p, rd_busy[p], m_rd_busy(p));
        end
      end
      n_checks++;
      if (any_pending !== m_any()) begin
        n_fail++; $display("FAIL rand_any c%0d got=%b exp=%b", c, any_pending, m_any());
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rd_addr = '0;
    idle();
    test_reset();
    test_basic();
    test_conflict();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
